// File: rtl/mult_seq_pkg.sv
// Shared encodings for the iterative multiplier responder on the EX multi-cycle
// start/annul/ready handshake.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    MulFree = 2'b00,
    MulZero = 2'b01,
    MulOn   = 2'b10,
    MulEnd  = 2'b11
  } mul_state_e;

  localparam logic MulResultReady    = 1'b1;
  localparam logic MulResultNotReady = 1'b0;
  localparam logic MulStart          = 1'b1;
  localparam logic MulStop           = 1'b0;
  localparam logic MulAnnul          = 1'b1;

  localparam int DoubleRegBusW = 64;

endpackage

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: one partial product per cycle, signed or
// unsigned, 2*DATA_W-bit product presented with ready_o until EX drops start_i.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_mult_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  mul_state_e            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [2*DATA_W-1:0]   acc, acc_nx;
  logic [DATA_W-1:0]     mcand, mcand_nx;
  logic [DATA_W-1:0]     mplier, mplier_nx;
  logic                  neg, neg_nx;
  logic [2*DATA_W-1:0]   result_nx;
  logic                  ready_nx;
  logic [2*DATA_W-1:0]   partial;
  logic [2*DATA_W-1:0]   sum;

  // 0x80..0 maps to itself, which is the correct magnitude when read unsigned.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                                input logic sgn);
    logic signed [DATA_W-1:0] sv;
    sv = $signed(v);
    return (sgn && sv < 0) ? ('0 - v) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_prod(input logic [2*DATA_W-1:0] p);
    return '0 - p;
  endfunction

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MulFree;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      result_o <= '0;
      ready_o  <= MulResultNotReady;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      acc      <= acc_nx;
      mcand    <= mcand_nx;
      mplier   <= mplier_nx;
      neg      <= neg_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

  // Next-state, iteration step and output staging
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    neg_nx    = neg;
    result_nx = result_o;
    ready_nx  = ready_o;
    partial   = mplier[0] ? ({{DATA_W{1'b0}}, mcand} << cnt) : '0;
    sum       = acc + partial;

    case (state)
      MulFree: begin
        result_nx = '0;
        ready_nx  = MulResultNotReady;
        if (start_i == MulStart && annul_i != MulAnnul) begin
          if (opdata1_i == '0 || opdata2_i == '0) begin
            state_nx = MulEnd;
            ready_nx = MulResultReady;
          end else begin
            mcand_nx  = abs_op(opdata1_i, signed_mult_i);
            mplier_nx = abs_op(opdata2_i, signed_mult_i);
            neg_nx    = signed_mult_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            acc_nx    = '0;
            cnt_nx    = '0;
            state_nx  = MulOn;
          end
        end
      end
      MulOn: begin
        if (annul_i == MulAnnul) begin
          state_nx  = MulFree;
          acc_nx    = '0;
          cnt_nx    = '0;
          result_nx = '0;
          ready_nx  = MulResultNotReady;
        end else begin
          acc_nx    = sum;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt + CNT_W'(1);
          if (cnt == CntLast) begin
            state_nx  = MulEnd;
            result_nx = neg ? neg_prod(sum) : sum;
            ready_nx  = MulResultReady;
          end
        end
      end
      MulEnd: begin
        // Held start keeps the result; a new op needs start low for an edge.
        if (start_i == MulStop || annul_i == MulAnnul) begin
          state_nx  = MulFree;
          result_nx = '0;
          ready_nx  = MulResultNotReady;
        end
      end
      default: begin
        state_nx  = MulFree;
        result_nx = '0;
        ready_nx  = MulResultNotReady;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: expected products queued at issue, compared
// when ready_o rises, plus latency, annul, reset and hold behaviour.
module tb_mult_seq;

  localparam int DATA_W = 32;

  logic                 clk;
  logic                 rst;
  logic                 signed_mult_i;
  logic [DATA_W-1:0]    opdata1_i;
  logic [DATA_W-1:0]    opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*DATA_W-1:0]  result_o;
  logic                 ready_o;

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];

  mult_seq #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_mult_i(signed_mult_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Issue one op (start left high), wait for ready, check latency and product.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input string tag);
    int n;
    int exp_lat;
    logic [63:0] e;
    exp_lat = (a == 0 || b == 0) ? 1 : 33;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_mult_i = s;
    start_i = 1'b1; annul_i = 1'b0;
    exp_q.push_back(model(a, b, s));
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) break;
    end
    if (!ready_o) n = 999;
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, "_res"}, result_o, e);
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rdy0"}, 64'(ready_o), 64'd0);
    chk({tag, "_res0"}, result_o, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rs;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_mult_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Unsigned max, then hold start with changing operands
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
    chk("umax_const", result_o, 64'hFFFF_FFFE_0000_0001);
    held = result_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      opdata1_i = $urandom; opdata2_i = $urandom;
      @(posedge clk); #1;
      chk("hold_rdy", 64'(ready_o), 64'd1);
      chk("hold_res", result_o, held);
    end
    drop_start("umax");

    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
    chk("s_m3x5_const", result_o, 64'hFFFF_FFFF_FFFF_FFF1);
    drop_start("s_m3x5");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minsq");
    chk("s_minsq_const", result_o, 64'h4000_0000_0000_0000);
    drop_start("s_minsq");
    do_op(32'h8000_0000, 32'd1, 1'b1, "s_minx1");
    chk("s_minx1_const", result_o, 64'hFFFF_FFFF_8000_0000);
    drop_start("s_minx1");

    // Zero shortcut
    do_op(32'd0, 32'h1234_5678, 1'b0, "zero_u");
    drop_start("zero_u");
    do_op(32'd0, 32'h1234_5678, 1'b1, "zero_s");
    drop_start("zero_s");
    do_op(32'h8765_4321, 32'd0, 1'b1, "zero_b");
    drop_start("zero_b");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i & 1);
      do_op(ra, rb, rs, "rand");
      drop_start("rand");
    end

    // Annul on the 10th MulOn edge, then immediate 7 x 6
    @(negedge clk);
    opdata1_i = 32'd123; opdata2_i = 32'd456; signed_mult_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("annul_busy_rdy", 64'(ready_o), 64'd0);
    end
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_rdy", 64'(ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    do_op(32'd7, 32'd6, 1'b0, "after_annul");
    chk("after_annul_const", result_o, 64'h2A);
    drop_start("after_annul");

    // Synchronous reset mid-iteration
    @(negedge clk);
    opdata1_i = 32'd99; opdata2_i = 32'd77; start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_quiet", 64'(ready_o), 64'd0);

    // Reset in MulEnd: nothing moves until the edge
    do_op(32'd1000, 32'd3, 1'b0, "pre_rst");
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_noedge_rdy", 64'(ready_o), 64'd1);
    chk("rst_noedge_res", result_o, 64'd3000);
    @(posedge clk); #1;
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    @(posedge clk);

    do_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, "final");
    drop_start("final");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Iterative 32x32 multiplier acting as the responder on the EX-stage multi-cycle start/annul/ready handshake, the same protocol EX already drives toward div.
EX raises start_i with operands, stalls via stallreq, and consumes result_o when ready_o is seen.
Radix-2 shift-add, one partial product per cycle, signed or unsigned, producing a 64-bit product for HI/LO write-back.
Replaces the single-cycle combinational multiply path for MULT/MULTU/MADD/MSUB.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W bits.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
signed_mult_i  input  1  1 = two's-complement operands, 0 = unsigned
opdata1_i  input  DATA_W  multiplicand, sampled only on the accepting edge
opdata2_i  input  DATA_W  multiplier, sampled only on the accepting edge
start_i  input  1  request; level-held by EX until it has taken the result
annul_i  input  1  abort current/pending operation
result_o  output  2*DATA_W  product, valid only while ready_o=1
ready_o  output  1  result valid (registered)

Behaviour:
- Reset (rst=1 at an edge, any state incl. mid-operation): state=MulFree, cnt=0, result_o=0, ready_o=0, internal accumulator/operand registers cleared.
- States: MulFree (idle), MulZero (unused, reserved encoding), MulOn (iterating), MulEnd (result presented).
- MulFree: on an edge with start_i=1 and annul_i=0:
  - if either operand == 0 -> MulEnd with product 0 (1-edge latency);
  - else latch |opdata1|, |opdata2| (abs only when signed_mult_i=1), latch neg_flag = signed_mult_i & (op1[DATA_W-1] ^ op2[DATA_W-1]), clear accumulator, cnt=0 -> MulOn.
  - start_i=1 with annul_i=1 is ignored (stay MulFree).
- MulOn: each edge: if multiplier LSB=1, accumulator += multiplicand<<cnt (2*DATA_W-bit add, no overflow possible); multiplier >>=1; cnt++.
  - annul_i=1 at an edge -> MulFree, accumulator discarded, ready_o stays 0.
  - On the edge where cnt==DATA_W-1, the last iteration is performed and state -> MulEnd; result_o = neg_flag ? two's-complement of accumulator : accumulator; ready_o=1.
- Latency: ready_o first high after 1+DATA_W rising edges counted from (and including) the accepting edge (33 for DATA_W=32); zero-operand shortcut: 1 edge.
- MulEnd: ready_o=1, result_o held stable.
  - start_i=0 or annul_i=1 at an edge -> MulFree, result_o=0, ready_o=0.
  - start_i stays 1 -> remain in MulEnd (no re-issue); a new operation needs start_i low for at least one edge.
- Abs of 0x80000000 in signed mode = 0x80000000 as unsigned; unsigned math handles it.
- Operand changes on opdata*_i after acceptance have no effect.
- signed_mult_i is only sampled on the accepting edge.

Decomposition:
- Shared defines file gains: MulFree/MulZero/MulOn/MulEnd state encodings (2 bits), MulResultReady/MulResultNotReady, MulStart/MulStop, MulAnnul constants, and a DoubleRegBus-width result bus (already present).
- Single module, no sub-module; counter width = clog2(DATA_W)+1.
- Top level adds mult_seq instance beside div; EX gets mult_opdata*_o/mult_start_o/signed_mult_o outputs and mult_result_i/mult_ready_i inputs, and its stallreq covers pending multiplies.

Test Plan:
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF, start held -> ready_o rises exactly 33 edges after acceptance, result_o=0xFFFFFFFE_00000001; drop start -> ready_o=0, result_o=0 next edge.
- Signed -3 (0xFFFFFFFD) x 5 -> 0xFFFFFFFF_FFFFFFF1; signed 0x80000000 x 0x80000000 -> 0x40000000_00000000; signed 0x80000000 x 1 -> 0xFFFFFFFF_80000000.
- Zero shortcut: 0 x 0x12345678 (either signedness) -> ready_o=1 one edge after acceptance, result_o=0.
- Annul at 10th MulOn edge -> MulFree, ready_o never asserted; immediate new start 7 x 6 -> 0x2A after 33 edges.
- Synchronous rst asserted mid-MulOn and while in MulEnd -> next edge ready_o=0, result_o=0, state MulFree; rst with no clock edge changes nothing.
- Hold/no-reissue: start_i held high 10 edges in MulEnd with operands changed -> result_o unchanged, no new computation; start low 1 edge then high -> new product computed.
